// File: rtl/mips_pkg.sv
// Shared types for the multicycle MIPS multiply/divide unit: opcode, FSM state
// encoding and the iteration count.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_t;

  localparam int MD_ITER = 32;

endpackage

// File: rtl/md_step.sv
// One combinational iteration of unsigned shift-add multiply or restoring
// divide on the 64-bit working register.
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] work,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] work_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_trial;
  logic             no_borrow;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum       = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    // Upper 33 bits after the left shift: the bit shifted out acts as the borrow guard.
    rem_trial = work[2*WIDTH-1:WIDTH-1];
    no_borrow = (rem_trial >= {1'b0, operand});
    diff      = rem_trial[WIDTH-1:0] - operand;
    work_next = '0;
    if (is_div) begin
      if (no_borrow) work_next = {diff, work[WIDTH-2:0], 1'b1};
      else           work_next = {work[2*WIDTH-2:0], 1'b0};
    end else begin
      if (work[0]) work_next = {sum, work[WIDTH-1:1]};
      else         work_next = {1'b0, work[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit: magnitudes are processed unsigned for
// 32 iterations, then sign-corrected into Hi/Lo in a final FIX cycle.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = MD_ITER
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] Aout,
  input  logic [WIDTH-1:0] Bout,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  md_state_t          state, state_next;
  logic [CNT_W-1:0]   counter;
  logic [2*WIDTH-1:0] work, work_next, product;
  logic [WIDTH-1:0]   operand;
  logic               is_div, neg_lo, neg_hi;

  logic               start_op, zero_div, launch, signed_op, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    start_op  = start && (state == IDLE);
    zero_div  = start_op && op[1] && (Bout == '0);
    launch    = start_op && !zero_div;
    signed_op = ~op[0];
    sign_a    = signed_op & Aout[WIDTH-1];
    sign_b    = signed_op & Bout[WIDTH-1];
    mag_a     = cond_neg(Aout, sign_a);
    mag_b     = cond_neg(Bout, sign_b);
    product   = cond_neg_wide(work, neg_lo);
  end

  assign busy = (state != IDLE);

  md_step #(.WIDTH(WIDTH)) u_step (
    .is_div    (is_div),
    .work      (work),
    .operand   (operand),
    .work_next (work_next)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = RUN;
      RUN:     if (counter == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      counter  <= '0;
      work     <= '0;
      operand  <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (zero_div) begin
            done     <= 1'b1;
            div_zero <= 1'b1;
          end else if (launch) begin
            counter <= '0;
            is_div  <= op[1];
            neg_lo  <= sign_a ^ sign_b;
            // Divide: dividend in the low half, divisor as operand; multiply: multiplier low.
            if (op[1]) begin
              work    <= {{WIDTH{1'b0}}, mag_a};
              operand <= mag_b;
              neg_hi  <= sign_a;
            end else begin
              work    <= {{WIDTH{1'b0}}, mag_b};
              operand <= mag_a;
              neg_hi  <= sign_a ^ sign_b;
            end
          end
        end
        RUN: begin
          work    <= work_next;
          counter <= counter + 1'b1;
        end
        FIX: begin
          if (is_div) begin
            Lo <= cond_neg(work[WIDTH-1:0], neg_lo);
            Hi <= cond_neg(work[2*WIDTH-1:WIDTH], neg_hi);
          end else begin
            Lo <= product[WIDTH-1:0];
            Hi <= product[2*WIDTH-1:WIDTH];
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus random operations checked
// against a 64-bit arithmetic reference model.
module tb_mult_div_unit;
  import mips_pkg::*;

  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  md_op_t      op = MD_MULT;
  logic [31:0] Aout = '0;
  logic [31:0] Bout = '0;
  logic        busy, done, div_zero;
  logic [31:0] Hi, Lo;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .Clk      (Clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .Aout     (Aout),
    .Bout     (Bout),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .Hi       (Hi),
    .Lo       (Lo)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Architectural result from plain signed/unsigned 64-bit arithmetic.
  function automatic void model(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic dz);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    dz = 1'b0;
    h  = exp_hi;
    l  = exp_lo;
    case (o)
      MD_MULT:  begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      MD_MULTU: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
      MD_DIV: begin
        if (b == 0) dz = 1'b1;
        else begin
          q = sa / sb; r = sa % sb;
          p = q; l = p[31:0];
          p = r; h = p[31:0];
        end
      end
      default: begin
        if (b == 0) dz = 1'b1;
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  task automatic launch(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
    op = o; Aout = a; Bout = b; start = 1'b1;
  endtask

  // Call with start already raised before the start edge; returns in the cycle done is high.
  task automatic wait_done(input string tag, input md_op_t o, input logic [31:0] a,
                           input logic [31:0] b, input int poke_at);
    logic [31:0] h, l;
    logic        dz;
    int          n;
    model(o, a, b, h, l, dz);
    @(posedge Clk); #1;
    start = 1'b0;
    Aout  = $urandom;
    Bout  = $urandom;
    check({tag, " busy_after_start"}, busy, !dz);
    n = 0;
    while (!done && n < 40) begin
      @(posedge Clk); #1;
      n++;
      if (n == poke_at) begin
        op = MD_DIVU; Aout = $urandom; Bout = 32'd3; start = 1'b1;
      end else start = 1'b0;
    end
    check({tag, " latency"}, n, dz ? 0 : 33);
    check({tag, " done"}, done, 1'b1);
    check({tag, " div_zero"}, div_zero, dz);
    check({tag, " busy_at_done"}, busy, 1'b0);
    check({tag, " hi"}, Hi, h);
    check({tag, " lo"}, Lo, l);
    exp_hi = h;
    exp_lo = l;
  endtask

  task automatic finish_pulse(input string tag);
    @(posedge Clk); #1;
    check({tag, " done_pulse_end"}, done, 1'b0);
    check({tag, " dz_pulse_end"}, div_zero, 1'b0);
  endtask

  task automatic run_op(input string tag, input md_op_t o, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    launch(o, a, b);
    wait_done(tag, o, a, b, -1);
    finish_pulse(tag);
  endtask

  logic [31:0] special [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  initial begin
    logic [31:0] ra, rb;
    md_op_t      ro;

    #2 reset = 1'b1;
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset div_zero", div_zero, 1'b0);
    check("reset hi", Hi, 32'h0);
    check("reset lo", Lo, 32'h0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) reset = 1'b0;

    run_op("mult_7_m3", MD_MULT, 32'd7, 32'hFFFF_FFFD);
    check("mult_7_m3 hi_const", Hi, 32'hFFFF_FFFF);
    check("mult_7_m3 lo_const", Lo, 32'hFFFF_FFEB);
    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max hi_const", Hi, 32'hFFFF_FFFE);
    check("multu_max lo_const", Lo, 32'h0000_0001);
    run_op("mult_m1_m1", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mult_m1_m1 lo_const", Lo, 32'h1);
    run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2 lo_const", Lo, 32'hFFFF_FFFD);
    check("div_m7_2 hi_const", Hi, 32'hFFFF_FFFF);
    run_op("divu_7_2", MD_DIVU, 32'd7, 32'd2);
    check("divu_7_2 lo_const", Lo, 32'd3);
    check("divu_7_2 hi_const", Hi, 32'd1);
    run_op("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_min_m1 lo_const", Lo, 32'h8000_0000);
    check("div_min_m1 hi_const", Hi, 32'h0);

    run_op("preload", MD_MULTU, 32'h1234_0000, 32'h0001_0000);
    run_op("div_zero", MD_DIV, 32'd5, 32'd0);
    check("div_zero hi_kept", Hi, 32'h1234);
    check("div_zero lo_kept", Lo, 32'h0);
    run_op("divu_zero", MD_DIVU, 32'hDEAD_BEEF, 32'd0);

    @(negedge Clk);
    launch(MD_MULT, 32'h0001_2345, 32'hFFFF_0F0F);
    wait_done("ignored_start", MD_MULT, 32'h0001_2345, 32'hFFFF_0F0F, 5);
    finish_pulse("ignored_start");

    @(negedge Clk);
    launch(MD_MULTU, 32'hCAFE_0001, 32'h0000_BEEF);
    wait_done("b2b_first", MD_MULTU, 32'hCAFE_0001, 32'h0000_BEEF, -1);
    launch(MD_DIV, 32'hFFFF_FF00, 32'd9);
    wait_done("b2b_second", MD_DIV, 32'hFFFF_FF00, 32'd9, -1);
    finish_pulse("b2b_second");

    @(negedge Clk);
    launch(MD_DIV, 32'd100, 32'd7);
    @(posedge Clk); #1 start = 1'b0;
    repeat (10) @(posedge Clk);
    #2 reset = 1'b1;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort hi", Hi, 32'h0);
    check("abort lo", Lo, 32'h0);
    @(negedge Clk) reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7);
    check("divu_100_7 lo_const", Lo, 32'd14);
    check("divu_100_7 hi_const", Hi, 32'd2);

    for (int i = 0; i < 40; i++) begin
      ro = md_op_t'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d", i), ro, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
